dtc_inverse_search: RTL
=======================

# dtc_inverse_search

Sequential inverse-lookup engine for the decision-tree classifier blocks. Given a 63-bit target code, it sweeps every 8-bit input through an attached combinational classifier, computes the Hamming distance between each classifier output and the target, and reports the input with the closest match. It sits beside a classifier instance in characterisation and regression datapaths, and is used to find which input produces a given output code.

## Interface
- IN_W, 8, classifier input width; sweep length is 2^IN_W.
- OUT_W, 63, classifier output and target width.
- DIST_W, 6, distance width; equals clog2(OUT_W+1).
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE or DONE.
- target  in  OUT_W  code to match; latched on the accepted start.
- cls_inp  out  IN_W  drives the attached classifier input.
- cls_outp  in  OUT_W  classifier output; combinational from cls_inp in the same cycle.
- busy  out  1  high while sweeping.
- done  out  1  one-cycle pulse when results are final.
- best_inp  out  IN_W  lowest-index input with minimum distance.
- best_dist  out  DIST_W  minimum Hamming distance found.
- exact  out  1  best_dist == 0.
- match_count  out  IN_W+1  number of inputs with distance 0 (range 0..2^IN_W).

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE/DONE + start: latch target, idx<=0, best_dist<=OUT_W, best_inp<=0, match_count<=0, then go to SCAN.
- SCAN: cls_inp=idx. Stage 1 registers diff=cls_outp^target_q and tag=idx. idx increments each cycle. When idx==2^IN_W-1, the FSM goes to DRAIN and cls_inp holds that value.
- Stage 2 (valid one cycle after stage 1):
  - d=popcount(diff).
  - If d<best_dist, update best_dist and best_inp. Comparison is strictly less, so ties keep the lowest index.
  - If d==0, increment match_count.
- DRAIN: flush the stage-1 and stage-2 valids, then go to DONE with done pulsed.
- DONE: results hold until the next accepted start. DONE behaves like IDLE for start.
- start while busy is ignored. target changes after the latch have no effect.
- The idx counter is IN_W+1 bits or uses an explicit last flag, so there is no wrap-around back to 0 mid-sweep.
- Reset at any time returns to IDLE with all outputs at their reset values. A pipeline in flight is discarded.
- Reset values: cls_inp=0, busy=0, done=0, best_inp=0, best_dist=OUT_W (63), exact=0, match_count=0.
- exact is registered alongside best_dist.

## Timing
- Edge E0 samples start. After E0: busy=1, cls_inp=0.
- After Ek (k=1..2^IN_W-1): cls_inp=k.
- The stage-1 capture for input k occurs at E(k+1). The best/match update for input k occurs at E(k+2).
- The last update happens at E(2^IN_W+1), which is E257. After E257: busy=0, done=1 for exactly one cycle, and the outputs are final.
- Start-to-done latency: 2^IN_W+1 cycles (257).
- A new start is accepted on the edge where done is high. The sweep restarts with no idle gap.
- best_dist, best_inp and match_count are intermediate while busy. The bench checks them only at done.

## Test plan
- Identity stub (cls_outp={55'b0,cls_inp}), target=63'h2A -> done 257 cycles after start, best_inp=8'h2A, best_dist=0, exact=1, match_count=1.
- Identity stub, target=63'h1FF -> best_inp=8'hFF, best_dist=1, exact=0, match_count=0.
- Constant stub (cls_outp=63'h5), target=63'h5 -> best_inp=0 (tie rule), best_dist=0, match_count=256. Target=63'h0 -> best_inp=0, best_dist=2, match_count=0.
- Identity stub, start pulsed again at cycle 100 of a sweep with a different target -> ignored. Results match the first target, and done arrives at cycle 257.
- rst_n low at cycle 120 of a sweep -> busy=0, done=0, best_dist=63, match_count=0, cls_inp=0 immediately. A subsequent start runs a full correct sweep.
- Back-to-back: start held high through done -> second sweep starts on the done edge. The second done is 257 cycles later, and the first results remain visible until overwritten.

Source files
------------

// File: rtl/dtc_inverse_search.sv
// Inverse-lookup sweep: drives every classifier input once, scores each output by
// Hamming distance to a latched target, and reports the closest (lowest-index) match.
module dtc_inverse_search #(
    parameter int IN_W   = 8,
    parameter int OUT_W  = 63,
    parameter int DIST_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OUT_W-1:0]  target,
    output logic [IN_W-1:0]   cls_inp,
    input  logic [OUT_W-1:0]  cls_outp,
    output logic              busy,
    output logic              done,
    output logic [IN_W-1:0]   best_inp,
    output logic [DIST_W-1:0] best_dist,
    output logic              exact,
    output logic [IN_W:0]     match_count
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t              state, state_nxt;
    logic [IN_W-1:0]     idx;
    logic                accept;
    logic                last;

    logic [OUT_W-1:0]    target_q;
    logic [OUT_W-1:0]    diff_p1;
    logic [IN_W-1:0]     tag_p1;
    logic                vld_p1;
    logic [DIST_W-1:0]   dist_p1;

    function automatic logic [DIST_W-1:0] popcount(input logic [OUT_W-1:0] v);
        logic [DIST_W-1:0] c;
        c = '0;
        for (int i = 0; i < OUT_W; i++) begin
            c = c + DIST_W'(v[i]);
        end
        return c;
    endfunction

    assign accept  = start && ((state == IDLE) || (state == DONE));
    assign last    = (idx == {IN_W{1'b1}});
    assign cls_inp = idx;
    assign busy    = (state == SCAN) || (state == DRAIN);
    assign dist_p1 = popcount(diff_p1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SCAN;
            SCAN:    if (last)  state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    if (start) state_nxt = SCAN;
            default: state_nxt = IDLE;
        endcase
    end

    // stage 1: capture the classifier response for the current input
    always_ff @(posedge clk) begin
        if (accept) begin
            target_q <= target;
        end
        diff_p1 <= cls_outp ^ target_q;
        tag_p1  <= idx;
    end

    // stage 2: score the captured response and update the running best
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            vld_p1      <= 1'b0;
            done        <= 1'b0;
            best_inp    <= '0;
            best_dist   <= DIST_W'(OUT_W);
            exact       <= 1'b0;
            match_count <= '0;
        end else begin
            vld_p1 <= (state == SCAN);
            done   <= (state == DRAIN);
            if (accept) begin
                idx         <= '0;
                best_inp    <= '0;
                best_dist   <= DIST_W'(OUT_W);
                exact       <= 1'b0;
                match_count <= '0;
            end else begin
                if ((state == SCAN) && !last) begin
                    idx <= idx + IN_W'(1);
                end
                if (vld_p1) begin
                    // strict less-than keeps the lowest index on ties
                    if (dist_p1 < best_dist) begin
                        best_dist <= dist_p1;
                        best_inp  <= tag_p1;
                        exact     <= (dist_p1 == '0);
                    end
                    if (dist_p1 == '0) begin
                        match_count <= match_count + (IN_W + 1)'(1);
                    end
                end
            end
        end
    end

endmodule
